// File: rtl/z80_bus_responder.sv
// Synchronous bus slave for the tv80s core: decodes memory, IO and interrupt-acknowledge
// cycles, stretches them with wait_n and issues one-cycle strobes to a RAM port and an IO port.
module z80_bus_responder #(
  parameter int unsigned MEM_WAIT   = 0,
  parameter int unsigned IO_WAIT    = 1,
  parameter logic [7:0]  IM2_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_LATCH, S_DONE} state_t;
  typedef enum logic [1:0] {K_MEM, K_IO, K_INTA} kind_t;

  localparam logic [3:0] MEM_WAIT_C = MEM_WAIT[3:0];
  localparam logic [3:0] IO_WAIT_C  = IO_WAIT[3:0];

  state_t      state_q;
  kind_t       kind_q;
  logic        wr_q;
  logic [3:0]  cnt_q;
  logic [7:0]  di_q;
  logic        wait_n_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic [7:0]  io_addr_q;
  logic [7:0]  io_wdata_q;
  logic        mem_we_q, mem_re_q, io_we_q, io_re_q;
  logic        bus_err_q;

  logic        det_inta, det_mem, det_io, det_any, released;
  kind_t       det_kind;
  logic [3:0]  det_cnt;
  logic        acc_go, acc_wr;
  kind_t       acc_kind;
  logic        mem_we_d, mem_re_d, io_we_d, io_re_d;

  assign det_inta = !m1_n && !iorq_n;
  assign det_mem  = !mreq_n && rfsh_n && (!rd_n || !wr_n);
  assign det_io   = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign det_any  = det_inta || det_mem || det_io;
  assign released = mreq_n && iorq_n;

  // Strobes are raised on the edge that enters ACCESS, so they are high for exactly that cycle.
  always_comb begin
    det_kind = det_inta ? K_INTA : (det_mem ? K_MEM : K_IO);
    det_cnt  = (det_kind == K_MEM) ? MEM_WAIT_C : IO_WAIT_C;
    acc_go   = 1'b0;
    acc_kind = kind_q;
    acc_wr   = wr_q;
    if (state_q == S_IDLE) begin
      acc_go   = det_any && (det_cnt == 4'd0);
      acc_kind = det_kind;
      acc_wr   = !wr_n;
    end else if (state_q == S_WAIT) begin
      acc_go = !released && (cnt_q == 4'd1);
    end
    mem_re_d = acc_go && (acc_kind == K_MEM) && !acc_wr;
    mem_we_d = acc_go && (acc_kind == K_MEM) && acc_wr;
    io_re_d  = acc_go && (acc_kind == K_IO) && !acc_wr;
    io_we_d  = acc_go && (acc_kind == K_IO) && acc_wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_MEM;
      wr_q        <= 1'b0;
      cnt_q       <= 4'd0;
      di_q        <= 8'h00;
      wait_n_q    <= 1'b1;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      io_addr_q   <= 8'h00;
      io_wdata_q  <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_re_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
      io_we_q  <= io_we_d;
      io_re_q  <= io_re_d;
      case (state_q)
        S_IDLE: begin
          if (det_any) begin
            kind_q   <= det_kind;
            wr_q     <= !wr_n;
            cnt_q    <= det_cnt;
            wait_n_q <= 1'b0;
            if (det_kind == K_MEM) begin
              mem_addr_q  <= A;
              mem_wdata_q <= dout;
            end else if (det_kind == K_IO) begin
              io_addr_q  <= A[7:0];
              io_wdata_q <= dout;
            end
            if (!mreq_n && !iorq_n && m1_n) bus_err_q <= 1'b1;
            state_q <= (det_cnt == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (released) begin
            state_q  <= S_IDLE;
            wait_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (kind_q == K_INTA) begin
            di_q     <= IM2_VECTOR;
            wait_n_q <= 1'b1;
            state_q  <= S_DONE;
          end else if (wr_q) begin
            wait_n_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
          di_q     <= (kind_q == K_MEM) ? mem_rdata : io_rdata;
          wait_n_q <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (released) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The wait counter is four bits wide; larger settings would silently wrap.
  always_ff @(posedge clk) begin
    assert (MEM_WAIT <= 15 && IO_WAIT <= 15);
  end

  assign di        = di_q;
  assign wait_n    = wait_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign io_we     = io_we_q;
  assign io_re     = io_re_q;
  assign bus_err   = bus_err_q;

endmodule
